mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Responder on the far side of the pipeline stall protocol: it accepts instruction-fetch and data-memory requests from the datapath.
- It serialises them onto the single-ported RAM and returns registered one-cycle `ihit` / `dhit` pulses with load data.
- Those hit pulses are what the pipeline hazard logic consumes to release stalls.
- It sits between the datapath and the RAM model/cache fill port.

Parameters:
- WORD_W, 32, data and address width in bits.
- MAX_WAIT, 15, RAM cycles without `ACCESS` before the access is dropped and retried.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- imemREN  in  1  instruction fetch request (level, held until `ihit`)
- imemaddr  in  WORD_W  fetch address
- dmemREN  in  1  data load request (level)
- dmemWEN  in  1  data store request (level)
- dmemaddr  in  WORD_W  data address
- dmemstore  in  WORD_W  store data
- ihit  out  1  one-cycle pulse: fetch complete, `imemload` valid
- dhit  out  1  one-cycle pulse: data access complete, `dmemload` valid on load
- imemload  out  WORD_W  fetched instruction (registered, holds until next `ihit`)
- dmemload  out  WORD_W  loaded data (registered, holds until next load `dhit`)
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramstate  in  2  FREE / BUSY / ACCESS / ERROR (`ramstate_t`)
- ramload  in  WORD_W  RAM read data

Behaviour:
- Reset values:
  - State IDLE.
  - All strobes and hits 0.
  - `imemload`, `dmemload`, `ramaddr`, `ramstore` 0.
  - Wait counter 0.
  - Grant register INST.
- States: IDLE, ACCESS, RESP, BACKOFF.
- IDLE:
  - `dmemREN` | `dmemWEN` → grant DATA.
  - Else `imemREN` → grant INST.
  - Else stay.
  - On grant, latch address, store data and operation type (read/write); next state ACCESS.
  - Data has fixed priority.
  - `dmemREN` & `dmemWEN` together is illegal; treat as write.
- ACCESS:
  - Drive `ramREN`/`ramWEN` from the latched op and `ramaddr`/`ramstore` from the latches.
  - Wait counter increments each cycle.
  - `ramstate`==ACCESS → capture `ramload` into the INST/DATA load register (reads only); next state RESP.
  - `ramstate`==ERROR, or counter reaches MAX_WAIT → next state BACKOFF.
- BACKOFF:
  - Strobes low for exactly one cycle, counter cleared.
  - Next state ACCESS with the same latched request.
- RESP:
  - Strobes low.
  - Assert `ihit` (INST) or `dhit` (DATA) only if the matching request is still asserted and its address equals the latched address.
  - Otherwise discard silently; this covers a request dropped or redirected by a pipeline flush.
  - Load register is not updated on a discarded response.
  - Next state IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; strobes asserted from cycle 1.
  - With RAM ACCESS at cycle k, hit is at cycle k+1.
  - Minimum 3 cycles from request to hit.
- Never more than one outstanding RAM access; never `ihit` and `dhit` in the same cycle.
- Wait counter width is `$clog2(MAX_WAIT+1)`; it saturates at MAX_WAIT and never wraps.
- Requests arriving while not in IDLE are ignored until return to IDLE.
- RST mid-access: immediate return to reset values; the RAM access is abandoned and no hit is issued.

Optional Feature:
- MEM_ARB_FAIR_EN defined: round-robin grant.
  - After a DATA grant completes with `dhit`, a pending `imemREN` wins the next IDLE arbitration over a pending data request.
  - After an INST grant, data wins.
  - This prevents fetch starvation under back-to-back loads/stores.
- Undefined: fixed data priority as above; the grant register is unused.

Decomposition:
- `aww_types_pkg` gets:
  - `arb_state_t` enum (IDLE, ACCESS, RESP, BACKOFF);
  - `grant_t` enum (INST, DATA);
  - MAX_WAIT default constant.
- `ramstate_t` and `word_t` come from `cpu_types_pkg`.
- Interface `mem_arbiter_if` with modports `ma` (block), `dp` (datapath), `ram` (RAM).
- No sub-module; single FSM plus counter.

Test Plan:
- Fetch only: `imemREN`=1, addr 0x0000_0040; RAM ACCESS on 2nd strobe cycle with `ramload` 0x2001_0005 → `ramREN` for 2 cycles, `ihit` one pulse, `imemload`=0x2001_0005, total 4 cycles.
- Simultaneous: `imemREN` and `dmemWEN` (addr 0x100, data 0xDEAD_BEEF) together → `ramWEN` first, `ramstore`=0xDEAD_BEEF, `dhit`; then fetch serviced and `ihit`; never both hits in one cycle.
- Flush discard: `imemREN` at 0x40, redirected to 0x80 during ACCESS → no `ihit` for 0x40, `imemload` unchanged, new fetch of 0x80 starts next IDLE.
- ERROR/timeout: `ramstate`=ERROR once, then BUSY for 20 cycles with MAX_WAIT=15 → one-cycle strobe gap after ERROR, another after 15 cycles; hit once ACCESS finally returns.
- Reset mid-access: RST pulse during ACCESS → strobes, hits, loads 0 next edge; state IDLE.
- MEM_ARB_FAIR_EN: continuous `dmemREN` plus `imemREN` → grants alternate DATA, INST, DATA; without the macro, `ihit` never asserts while `dmemREN` held.

Source files
------------

// File: rtl/aww_types_pkg.sv
// aww_types_pkg: arbiter-local types.
//   arb_state_t      - arbiter FSM states
//   grant_t          - which requester owns the RAM
//   MAX_WAIT_DEFAULT - RAM cycles tolerated without ACCESS before a retry
// The arbiter state names overlap with ramstate_t (ACCESS), so users of both
// packages refer to the RAM-side names with the cpu_types_pkg:: prefix.
package aww_types_pkg;
    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESP    = 2'd2,
        BACKOFF = 2'd3
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } grant_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the datapath, the memory arbiter and the
// RAM model.
//   word_t     - one machine word (data and addresses)
//   ramstate_t - RAM handshake state: FREE, BUSY, ACCESS (data ready or
//                write taken), ERROR (access failed, must be retried)
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every signal between the datapath, the memory
// arbiter and the RAM.
//   ma  - arbiter view (takes requests and RAM status, drives hits and strobes)
//   dp  - datapath view (drives requests, takes hits and load data)
//   ram - RAM view (takes strobes, drives status and read data)
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    ramstate_t ramstate;
    word_t     ramload;

    modport ma  (input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
                        ramstate, ramload,
                 output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore);
    modport dp  (output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
                 input  ihit, dhit, imemload, dmemload);
    modport ram (input  ramREN, ramWEN, ramaddr, ramstore,
                 output ramstate, ramload);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data requests onto one
// single-ported RAM and returns registered one-cycle ihit/dhit pulses.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   imemREN/imemaddr         fetch request (level, held until ihit)
//   dmemREN/dmemWEN          data load/store request (level); both = store
//   dmemaddr/dmemstore       data address / store data
//   ihit/dhit                one-cycle completion pulses (never together)
//   imemload/dmemload        load registers, hold until the next hit
//   ramREN/ramWEN            RAM strobes, high only while an access is live
//   ramaddr/ramstore         latched request address / store data
//   ramstate/ramload         RAM status and read data
//
// Configuration macro
//   MEM_ARB_FAIR_EN - when defined, a fetch pending after a completed data
//                     access wins the next arbitration (round robin).
//                     Undefined: data always has priority.
//
// Flow: IDLE grants and latches -> ACCESS strobes the RAM until ACCESS
// (-> RESP) or ERROR/timeout (-> BACKOFF, one quiet cycle, then ACCESS again).
// RESP is the hit cycle. The hit is decided on the RAM ACCESS cycle, so a
// request withdrawn or re-addressed by a flush before then is dropped silently.
module mem_arbiter
    import aww_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      imemREN,
    input  logic [WORD_W-1:0]         imemaddr,
    input  logic                      dmemREN,
    input  logic                      dmemWEN,
    input  logic [WORD_W-1:0]         dmemaddr,
    input  logic [WORD_W-1:0]         dmemstore,
    output logic                      ihit,
    output logic                      dhit,
    output logic [WORD_W-1:0]         imemload,
    output logic [WORD_W-1:0]         dmemload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [WORD_W-1:0]         ramaddr,
    output logic [WORD_W-1:0]         ramstore,
    input  cpu_types_pkg::ramstate_t  ramstate,
    input  logic [WORD_W-1:0]         ramload
);
    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    grant_t            cur_q, cur_d;        // requester owning the live access
    logic              wr_q, wr_d;          // latched operation: 1 = write
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              ihit_q, ihit_d;
    logic              dhit_q, dhit_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;
    logic              data_req_s;
    logic              pick_inst_s;

    assign data_req_s = dmemREN | dmemWEN;

`ifdef MEM_ARB_FAIR_EN
    grant_t last_q, last_d;                 // round-robin grant register

    // A completed data access hands the next arbitration to a waiting fetch.
    assign pick_inst_s = imemREN & (~data_req_s | (last_q == DATA));
`else
    // Fixed priority: fetch wins only when no data request is pending.
    assign pick_inst_s = imemREN & ~data_req_s;
`endif

    // Next-state, strobe, hit and load-register computation.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;
`ifdef MEM_ARB_FAIR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_inst_s) begin
                    cur_d   = INST;
                    wr_d    = 1'b0;
                    addr_d  = imemaddr;
                    ren_d   = 1'b1;
                    state_d = ACCESS;
`ifdef MEM_ARB_FAIR_EN
                    last_d  = INST;
`endif
                end else if (data_req_s) begin
                    // REN and WEN together is treated as a store.
                    cur_d   = DATA;
                    wr_d    = dmemWEN;
                    addr_d  = dmemaddr;
                    store_d = dmemstore;
                    ren_d   = ~dmemWEN;
                    wen_d   = dmemWEN;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (ramstate == cpu_types_pkg::ACCESS) begin
                    state_d = RESP;
                    // Only a requester still asking for the same address gets the hit.
                    if (cur_q == INST) begin
                        if (imemREN && (imemaddr == addr_q)) begin
                            ihit_d  = 1'b1;
                            iload_d = ramload;
                        end else begin
                            ihit_d  = 1'b0;
                        end
                    end else begin
                        if (data_req_s && (dmemaddr == addr_q)) begin
                            dhit_d = 1'b1;
`ifdef MEM_ARB_FAIR_EN
                            last_d = DATA;
`endif
                            if (!wr_q) begin
                                dload_d = ramload;
                            end else begin
                                dload_d = dload_q;
                            end
                        end else begin
                            dhit_d = 1'b0;
                        end
                    end
                end else if ((ramstate == cpu_types_pkg::ERROR) || (cnt_d == CNT_MAX)) begin
                    state_d = BACKOFF;
                end else begin
                    ren_d = ~wr_q;
                    wen_d = wr_q;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            BACKOFF: begin
                // One quiet cycle, then the same latched request is retried.
                cnt_d   = '0;
                ren_d   = ~wr_q;
                wen_d   = wr_q;
                state_d = ACCESS;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; RST abandons any access immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cur_q   <= INST;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            cnt_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
`ifdef MEM_ARB_FAIR_EN
            last_q  <= INST;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
`ifdef MEM_ARB_FAIR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = iload_q;
    assign dmemload = dload_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAX_WAIT = 15;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    mem_arbiter_if bus();

    mem_arbiter #(.WORD_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .imemREN(bus.imemREN), .imemaddr(bus.imemaddr),
        .dmemREN(bus.dmemREN), .dmemWEN(bus.dmemWEN),
        .dmemaddr(bus.dmemaddr), .dmemstore(bus.dmemstore),
        .ihit(bus.ihit), .dhit(bus.dhit),
        .imemload(bus.imemload), .dmemload(bus.dmemload),
        .ramREN(bus.ramREN), .ramWEN(bus.ramWEN),
        .ramaddr(bus.ramaddr), .ramstore(bus.ramstore),
        .ramstate(bus.ramstate), .ramload(bus.ramload)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] exp);
        check(name, act, exp);
        check({name, "_model"}, mdl, exp);
    endtask

    task automatic nxt();
        @(negedge CLK);
        #1;
    endtask

    // ---------------- reference model (expected outputs of the current cycle)
    bit          e_ren, e_wen, e_ihit, e_dhit, e_rst;
    logic [31:0] e_addr = 32'h0, e_store = 32'h0, e_iload = 32'h0, e_dload = 32'h0;
    bit          t_valid, t_data, t_wr, t_resp, last_data;
    int          run;

    task automatic model_step();
        bit nr, nw, ni, nd, want_d, take_i;
        nr = 1'b0; nw = 1'b0; ni = 1'b0; nd = 1'b0;
        if (RST) begin
            e_addr = 32'h0; e_store = 32'h0; e_iload = 32'h0; e_dload = 32'h0;
            e_rst = 1'b1; t_valid = 1'b0; t_resp = 1'b0; last_data = 1'b0; run = 0;
        end else begin
            e_rst = 1'b0;
            if (!t_valid) begin
                want_d = bus.dmemREN || bus.dmemWEN;
                take_i = bus.imemREN && (!want_d || (FAIR && last_data));
                if (take_i || want_d) begin
                    t_valid = 1'b1;
                    t_data  = !take_i;
                    t_wr    = !take_i && bus.dmemWEN;
                    run     = 0;
                    e_addr  = take_i ? bus.imemaddr : bus.dmemaddr;
                    if (!take_i) e_store = bus.dmemstore;
                    if (take_i) last_data = 1'b0;
                    nr = !t_wr; nw = t_wr;
                end
            end else if (t_resp) begin
                t_valid = 1'b0;
                t_resp  = 1'b0;
            end else if (e_ren || e_wen) begin
                run++;
                if (bus.ramstate == ACCESS) begin
                    t_resp = 1'b1;
                    if (!t_data && bus.imemREN && bus.imemaddr == e_addr) begin
                        ni = 1'b1; e_iload = bus.ramload;
                    end
                    if (t_data && (bus.dmemREN || bus.dmemWEN) && bus.dmemaddr == e_addr) begin
                        nd = 1'b1; last_data = 1'b1;
                        if (!t_wr) e_dload = bus.ramload;
                    end
                end else if (bus.ramstate == ERROR || run >= MAX_WAIT) begin
                    run = 0;                      // strobes drop for one cycle
                end else begin
                    nr = !t_wr; nw = t_wr;
                end
            end else begin
                nr = !t_wr; nw = t_wr;            // quiet cycle over, retry
            end
        end
        e_ren = nr; e_wen = nw; e_ihit = ni; e_dhit = nd;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // ---------------- per-cycle compare
    initial begin
        forever begin
            @(negedge CLK);
            check("ramREN", bus.ramREN, e_ren);
            check("ramWEN", bus.ramWEN, e_wen);
            check("ihit", bus.ihit, e_ihit);
            check("dhit", bus.dhit, e_dhit);
            check("one_hit", bus.ihit & bus.dhit, 32'h0);
            check("imemload", bus.imemload, e_iload);
            check("dmemload", bus.dmemload, e_dload);
            if (e_ren || e_wen || e_rst) check("ramaddr", bus.ramaddr, e_addr);
            if (e_wen || e_rst) check("ramstore", bus.ramstore, e_store);
        end
    end

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic new_data();
        int r;
        r = $urandom_range(0, 99);
        bus.dmemREN   = (r < 50) || (r >= 97);
        bus.dmemWEN   = (r >= 50);
        bus.dmemaddr  = rand_addr();
        bus.dmemstore = $urandom;
    endtask

    bit ren_hist[1:22];
    int ren_cnt, ih_cnt, ih, dh, first_d, r;
    bit slow;

    // ---------------- stimulus
    initial begin
        bus.imemREN = 1'b0; bus.imemaddr = 32'h0;
        bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = 32'h0; bus.dmemstore = 32'h0;
        bus.ramstate = FREE; bus.ramload = 32'h0;
        RST = 1'b1;
        nxt(); nxt();
        lit("rst_ren", bus.ramREN, e_ren, 32'h0);
        lit("rst_ihit", bus.ihit, e_ihit, 32'h0);
        lit("rst_iload", bus.imemload, e_iload, 32'h0);
        lit("rst_addr", bus.ramaddr, e_addr, 32'h0);
        RST = 1'b0;
        nxt();

        // Fetch only: RAM ACCESS on the second strobe cycle.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0040;
        nxt(); lit("a_ren1", bus.ramREN, e_ren, 32'h1); bus.ramstate = BUSY;
        nxt(); lit("a_ren2", bus.ramREN, e_ren, 32'h1);
        bus.ramstate = ACCESS; bus.ramload = 32'h2001_0005;
        nxt(); lit("a_ren3", bus.ramREN, e_ren, 32'h0);
        lit("a_ihit", bus.ihit, e_ihit, 32'h1);
        lit("a_iload", bus.imemload, e_iload, 32'h2001_0005);
        bus.imemREN = 1'b0; bus.ramstate = FREE;
        nxt(); lit("a_ihit_end", bus.ihit, e_ihit, 32'h0);

        // Simultaneous fetch and store: store first.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h300;
        bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'hDEAD_BEEF;
        nxt(); lit("b_wen", bus.ramWEN, e_wen, 32'h1);
        lit("b_ren", bus.ramREN, e_ren, 32'h0);
        lit("b_store", bus.ramstore, e_store, 32'hDEAD_BEEF);
        lit("b_addr", bus.ramaddr, e_addr, 32'h100);
        bus.ramstate = ACCESS;
        nxt(); lit("b_dhit", bus.dhit, e_dhit, 32'h1); lit("b_no_ihit", bus.ihit, e_ihit, 32'h0);
        bus.dmemWEN = 1'b0; bus.ramstate = FREE;
        nxt(); lit("b_gap", bus.ramREN, e_ren, 32'h0);
        nxt(); lit("b_fetch", bus.ramREN, e_ren, 32'h1); lit("b_faddr", bus.ramaddr, e_addr, 32'h300);
        bus.ramstate = ACCESS; bus.ramload = 32'h0000_1111;
        nxt(); lit("b_ihit", bus.ihit, e_ihit, 32'h1); lit("b_no_dhit", bus.dhit, e_dhit, 32'h0);
        bus.imemREN = 1'b0; bus.ramstate = FREE;
        nxt();

        // Flush: fetch redirected during ACCESS is discarded.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        nxt(); bus.ramstate = BUSY; bus.imemaddr = 32'h80;
        nxt(); bus.ramstate = ACCESS; bus.ramload = 32'h0BAD_0BAD;
        nxt(); lit("c_no_ihit", bus.ihit, e_ihit, 32'h0);
        lit("c_iload_kept", bus.imemload, e_iload, 32'h0000_1111);
        bus.ramstate = FREE;
        nxt();
        nxt(); lit("c_refetch", bus.ramaddr, e_addr, 32'h80);
        bus.ramstate = ACCESS; bus.ramload = 32'h8080_8080;
        nxt(); lit("c_ihit", bus.ihit, e_ihit, 32'h1);
        check("c_iload", bus.imemload, 32'h8080_8080);
        bus.imemREN = 1'b0; bus.ramstate = FREE;
        nxt();

        // ERROR once, then BUSY until timeout, then ACCESS.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h200;
        ren_cnt = 0; ih_cnt = 0;
        for (int c = 1; c <= 22; c++) begin
            nxt();
            ren_hist[c] = bus.ramREN;
            ren_cnt += int'(bus.ramREN);
            ih_cnt  += int'(bus.ihit);
            bus.ramstate = (c == 1) ? ERROR : ((c == 21) ? ACCESS : BUSY);
            bus.ramload  = 32'h1234_5678;
        end
        check("d_gap_err", 32'(ren_hist[2]), 32'h0);
        check("d_ren_17", 32'(ren_hist[17]), 32'h1);
        check("d_gap_tmo", 32'(ren_hist[18]), 32'h0);
        check("d_ren_19", 32'(ren_hist[19]), 32'h1);
        check("d_ren_cnt", ren_cnt, 32'd19);
        check("d_ihit_cnt", ih_cnt, 32'd1);
        check("d_ihit", bus.ihit, 32'h1);
        check("d_iload", bus.imemload, 32'h1234_5678);
        bus.imemREN = 1'b0; bus.ramstate = FREE;
        nxt();

        // Reset in the middle of an access.
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h44;
        nxt(); check("e_ren", bus.ramREN, 32'h1);
        RST = 1'b1; bus.ramstate = BUSY;
        nxt(); lit("e_ren0", bus.ramREN, e_ren, 32'h0);
        lit("e_dhit0", bus.dhit, e_dhit, 32'h0);
        lit("e_iload0", bus.imemload, e_iload, 32'h0);
        lit("e_dload0", bus.dmemload, e_dload, 32'h0);
        lit("e_addr0", bus.ramaddr, e_addr, 32'h0);
        RST = 1'b0; bus.dmemREN = 1'b0; bus.ramstate = FREE;
        nxt(); check("e_no_resume", bus.ramREN, 32'h0);

        // Continuous load plus fetch: arbitration policy.
        bus.imemREN = 1'b1; bus.imemaddr = 32'h500;
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h600;
        bus.ramstate = ACCESS;
        ih = 0; dh = 0; first_d = 0;
        for (int c = 1; c <= 30; c++) begin
            nxt();
            if (bus.dhit && ih == 0 && dh == 0) first_d = 1;
            ih += int'(bus.ihit);
            dh += int'(bus.dhit);
            bus.ramload = 32'(c);
        end
`ifdef MEM_ARB_FAIR_EN
        check("f_ihits", ih, 32'd5);
        check("f_dhits", dh, 32'd5);
        check("f_first_d", first_d, 32'd1);
`else
        check("f_ihits", ih, 32'd0);
        check("f_dhits", dh, 32'd10);
`endif
        bus.imemREN = 1'b0; bus.dmemREN = 1'b0; bus.ramstate = FREE;
        nxt();

        // Randomized traffic against the model.
        slow = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            nxt();
            if (c % 250 == 0) slow = ($urandom_range(0, 3) == 0);
            if (RST) RST = 1'b0;
            else if ($urandom_range(0, 499) == 0) RST = 1'b1;
            r = $urandom_range(0, 99);
            if (e_ren || e_wen)
                bus.ramstate = (r < (slow ? 2 : 40)) ? ACCESS :
                               ((r < (slow ? 4 : 45)) ? ERROR : BUSY);
            else
                bus.ramstate = ramstate_t'($urandom_range(0, 3));
            bus.ramload = $urandom;
            if (e_ihit) begin
                bus.imemREN = ($urandom_range(0, 3) != 0);
                bus.imemaddr = rand_addr();
            end else if (!bus.imemREN) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.imemREN = 1'b1; bus.imemaddr = rand_addr();
                end
            end else begin
                r = $urandom_range(0, 99);
                if (r < 3) bus.imemaddr = rand_addr();
                else if (r < 5) bus.imemREN = 1'b0;
            end
            if (e_dhit) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
                end else begin
                    new_data();
                end
            end else if (!(bus.dmemREN || bus.dmemWEN)) begin
                if ($urandom_range(0, 3) == 0) new_data();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 3) bus.dmemaddr = rand_addr();
                else if (r < 5) begin bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; end
            end
        end
        RST = 1'b0;
        nxt();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
